booth_ctrl: RTL and testbench

Sequencing FSM for the 8-bit radix-2 Booth multiplier datapath (accumulator register A, multiplier register Q with Q[-1] bit, multiplicand register M, adder/subtractor, shared 8-bit output bus). It runs one multiplication per start request:

- loads operands;
- runs N add/subtract-then-shift iterations from the Booth pair {Q[0], Q[-1]};
- drives the 2N-bit product onto the shared bus as A then Q;
- pulses done.

It contains no datapath arithmetic, only state, an iteration counter and control decode.

---
 rtl/booth_ctrl.sv | 121 ++++++++++++
 tb/tb_booth_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath: operand load,
// N add/sub-then-shift iterations, product readout as A then Q, done pulse.
module booth_ctrl #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic          q0,
    input  logic          q_m1,
    output logic          ld_m,
    output logic          ld_q,
    output logic          clr_a,
    output logic          ld_sum,
    output logic          sub,
    output logic          sh_r,
    output logic          oe_a,
    output logic          oe_q,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_M,
        S_LD_Q,
        S_TEST,
        S_SHIFT,
        S_OUT_A,
        S_OUT_Q,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_last;

    assign cnt_last = (cnt_q == CW'(N - 1));
    assign cnt      = cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value; the async reset forces IDLE and zero outputs at once.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path
    // through the case leaves a value unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_m    = 1'b0;
        ld_q    = 1'b0;
        clr_a   = 1'b0;
        ld_sum  = 1'b0;
        sub     = 1'b0;
        sh_r    = 1'b0;
        oe_a    = 1'b0;
        oe_q    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_LD_M;
            end
            S_LD_M: begin
                ld_m    = 1'b1;
                clr_a   = 1'b1;
                state_d = S_LD_Q;
            end
            S_LD_Q: begin
                ld_q    = 1'b1;
                cnt_d   = '0;
                state_d = S_TEST;
            end
            S_TEST: begin
                // Booth pair 10 subtracts M, 01 adds M, 00/11 leave A alone.
                ld_sum  = q0 ^ q_m1;
                sub     = q0 & ~q_m1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sh_r = 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_OUT_A;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_TEST;
                end
            end
            S_OUT_A: begin
                oe_a    = 1'b1;
                state_d = S_OUT_Q;
            end
            S_OUT_Q: begin
                oe_q    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl: models the Q/Q[-1] shift path to feed the
// Booth pair back, and checks cycle timing, decode counts and exclusivity.
module tb_booth_ctrl;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic          q0;
    logic          q_m1;
    logic          ld_m, ld_q, clr_a, ld_sum, sub, sh_r, oe_a, oe_q, busy, done;
    logic [CW-1:0] cnt;

    booth_ctrl #(.N(N), .CW(CW)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .start  (start),
        .q0     (q0),
        .q_m1   (q_m1),
        .ld_m   (ld_m),
        .ld_q   (ld_q),
        .clr_a  (clr_a),
        .ld_sum (ld_sum),
        .sub    (sub),
        .sh_r   (sh_r),
        .oe_a   (oe_a),
        .oe_q   (oe_q),
        .busy   (busy),
        .done   (done),
        .cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-run observations.
    int c_ldsum, c_sub, c_shr, c_busy, c_done;
    int cyc_oea, cyc_oeq, cyc_done;
    logic busy_after, ldm_after;
    // Accumulated across all runs.
    int excl_err = 0;
    int cnt_err  = 0;
    int dec_err  = 0;

    // Datapath model: multiplier register and its Q[-1] bit.
    logic [7:0] mq;
    logic       mqm1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [10:0] outs();
        return {ld_m, ld_q, clr_a, ld_sum, sub, sh_r, oe_a, oe_q, busy, done, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE. rnd drives random Booth pairs; hold keeps
    // start high throughout; abort_shift>0 returns during that SHIFT cycle.
    task automatic run_op(input logic [7:0] qval, input bit rnd, input bit hold,
                          input int abort_shift);
        logic tst;
        c_ldsum = 0; c_sub = 0; c_shr = 0; c_busy = 0; c_done = 0;
        cyc_oea = -1; cyc_oeq = -1; cyc_done = -1;
        busy_after = 1'bx; ldm_after = 1'bx;
        mq = 8'h00; mqm1 = 1'b0;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (rnd) begin
                q0   = 1'($urandom);
                q_m1 = 1'($urandom);
            end else begin
                q0   = mq[0];
                q_m1 = mqm1;
            end
            #1;
            if ((oe_a && oe_q) || !$onehot0({ld_sum, sh_r, ld_m, ld_q, oe_a, oe_q}) ||
                (cnt > CW'(N - 1)))
                excl_err++;
            tst = busy && !(ld_m || ld_q || clr_a || sh_r || oe_a || oe_q || done);
            if (tst && ((ld_sum !== (q0 ^ q_m1)) || (ld_sum && sub !== (q0 & ~q_m1))))
                dec_err++;
            if (!tst && (ld_sum || sub)) dec_err++;
            if (cyc_done < 0 && busy) c_busy++;
            if (ld_sum) c_ldsum++;
            if (ld_sum && sub) c_sub++;
            if (oe_a && cyc_oea < 0) cyc_oea = c;
            if (oe_q && cyc_oeq < 0) cyc_oeq = c;
            if (sh_r) begin
                if (cnt !== CW'(c_shr)) cnt_err++;
                c_shr++;
                if (abort_shift > 0 && c_shr == abort_shift) return;
            end
            if (cyc_done > 0 && c == cyc_done + 1) busy_after = busy;
            if (cyc_done > 0 && c == cyc_done + 2) begin
                ldm_after = ld_m;
                break;
            end
            if (done) begin
                c_done++;
                if (cyc_done < 0) cyc_done = c;
                if (!hold) break;
            end
            if (ld_q) mq = qval;
            if (clr_a) mqm1 = 1'b0;
            if (sh_r) begin
                mqm1 = mq[0];
                mq   = {1'b0, mq[7:1]};
            end
            @(posedge clk);
        end
        start = 1'b0;
        step();
    endtask

    initial begin
        rst_b = 1'b0;
        start = 1'b0;
        q0    = 1'b0;
        q_m1  = 1'b0;

        // 1. Reset and idle.
        repeat (3) step();
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_cnt", 32'(cnt), 32'd0);
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_outs", 32'(outs()), 32'd0);
        end
        check("idle_cnt", 32'(cnt), 32'd0);

        // 2. Q=0x05: sub, add, sub, add, none x4.
        run_op(8'h05, 1'b0, 1'b0, 0);
        check("q05_ldsum", c_ldsum, 4);
        check("q05_sub", c_sub, 2);
        check("q05_shr", c_shr, 8);
        check("q05_oe_a_cyc", cyc_oea, 19);
        check("q05_oe_q_cyc", cyc_oeq, 20);
        check("q05_done_cyc", cyc_done, 21);
        check("q05_busy_cycles", c_busy, 21);
        check("q05_idle_after", 32'(outs()), 32'd0);

        // 3. Q=0xFF: only iteration 0 subtracts.
        run_op(8'hFF, 1'b0, 1'b0, 0);
        check("qff_ldsum", c_ldsum, 1);
        check("qff_sub", c_sub, 1);
        check("qff_shr", c_shr, 8);
        check("qff_done_cyc", cyc_done, 21);

        // 4. start held high: one op, IDLE gap, then a new LD_M.
        run_op(8'h05, 1'b0, 1'b1, 0);
        check("hold_done_cyc", cyc_done, 21);
        check("hold_done_count", c_done, 1);
        check("hold_busy_cycles", c_busy, 21);
        check("hold_idle_gap_busy", 32'(busy_after), 32'd0);
        check("hold_next_ld_m", 32'(ldm_after), 32'd1);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        step();

        // 5. Reset during the 5th SHIFT.
        run_op(8'h05, 1'b0, 1'b0, 5);
        check("abort_reached_shift5", c_shr, 5);
        check("abort_cnt_before", 32'(cnt), 32'd4);
        rst_b = 1'b0;
        #1;
        check("abort_outs", 32'(outs()), 32'd0);
        check("abort_cnt", 32'(cnt), 32'd0);
        step();
        check("abort_held_outs", 32'(outs()), 32'd0);
        rst_b = 1'b1;
        step();
        step();
        check("abort_idle_outs", 32'(outs()), 32'd0);
        run_op(8'h05, 1'b0, 1'b0, 0);
        check("post_abort_done_cyc", cyc_done, 21);
        check("post_abort_busy", c_busy, 21);
        check("post_abort_ldsum", c_ldsum, 4);

        // 6. Random Booth pairs with exclusivity monitoring.
        for (int r = 0; r < 3; r++) begin
            run_op(8'h00, 1'b1, 1'b0, 0);
            check("rnd_done_cyc", cyc_done, 21);
            check("rnd_shr", c_shr, 8);
        end
        check("exclusivity_errors", excl_err, 0);
        check("cnt_sequence_errors", cnt_err, 0);
        check("decode_errors", dec_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
